lab3_mem_blocking_cache_2way: RTL and testbench
===============================================

# lab3_mem_blocking_cache_2way

Parametrised two-way set-associative, write-back, write-allocate blocking cache with its own control FSM, per-set LRU, and valid/dirty state. It sits between a processor-side 4B memory port and a 16B main-memory port, and replaces the direct-mapped base cache. It handles one request at a time, and set count and index shift are generics.

## Interface
- p_num_sets, default 8: sets per way; power of 2, ≥2. Capacity = 2·p_num_sets·16B.
- p_idx_shamt, default 0: extra shift applied to the set index, for bank interleaving.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- cachereq_val / cachereq_rdy  in/out  1/1  cache request handshake.
- cachereq_msg  in  mem_req_4B_t  type_, opaque, addr, len, data.
- cacheresp_val / cacheresp_rdy  out/in  1/1  cache response handshake.
- cacheresp_msg  out  mem_resp_4B_t  type_, opaque, test, len, data.
- memreq_val / memreq_rdy  out/in  1/1  memory request handshake.
- memreq_msg  out  mem_req_16B_t  memory request.
- memresp_val / memresp_rdy  in/out  1/1  memory response handshake.
- memresp_msg  in  mem_resp_16B_t  memory response.

## Operation
- Address fields:
  - offset = addr[3:0]; word select = addr[3:2].
  - index = addr[4+p_idx_shamt +: $clog2(p_num_sets)].
  - stored tag = addr[31:4], the full 28 bits.
- Per set: two tags, valid[2], dirty[2], one LRU bit. The LRU bit names the way to evict next.
- Request types: 0 = read, 1 = write, 2 = init. Other encodings are treated as read.
- FSM states: IDLE, TC, IN, RD, WD, EP, ER, EW, RR, RW, RU, WAIT.
  - IDLE: cachereq_rdy=1. A fire latches type, opaque, addr and data, then → TC.
  - TC: compare both ways; hit = valid && tag match (at most one way matches).
    - Init → IN.
    - Read hit → RD; write hit → WD.
    - Miss → victim selection:
      - victim = lowest-numbered invalid way, else the LRU way;
      - victim dirty → EP; clean → RR.
  - IN:
    - Way = the matching way, else the victim.
    - Write tag and the word (byte enables for that word only); set valid, clear dirty.
    - → WAIT.
  - RD: read line, select word. → WAIT.
  - WD: write word; set dirty. → WAIT.
  - EP: latch victim line and evict address = {victim tag, 4'b0}. → ER.
  - ER: memreq_val=1, type write, opaque 0, len 0, data = victim line. On fire → EW.
  - EW: memresp_rdy=1. On fire (data ignored) → RR.
  - RR: memreq_val=1, type read, addr = {addr[31:4], 4'b0}, len 0. On fire → RW.
  - RW: memresp_rdy=1. On fire latch the line → RU.
  - RU: write the full line and tag into the victim way; valid=1, dirty=0. Then → RD or WD as the request type dictates, using the victim way.
  - WAIT: cacheresp_val=1. On fire → IDLE.
- Response message:
  - type_ = request type; opaque = request opaque; len = 0.
  - data = selected word for reads, 0 otherwise.
  - test = 1 if TC found a hit for a read or write; 0 on a miss or init.
- LRU update: on entering IN, RD or WD, LRU[set] ← the way not used.
- Write data is replicated ×4; byte enables select word addr[3:2].

## Timing
- Reset: state=IDLE; all valid, dirty and LRU bits cleared; tag/data contents don't-care.
  - While reset is high, cachereq_rdy, cacheresp_val, memreq_val and memresp_rdy are all 0; all message outputs are 0.
  - cachereq_rdy=1 on the first cycle after reset falls.
- Reset asserted mid-miss aborts the operation; an outstanding memory response is neither awaited nor consumed.
- Hit latency: request fires in cycle N; cacheresp_val=1 in cycle N+3 (IDLE→TC→RD/WD/IN→WAIT).
- Clean miss: N+3 + memreq stall + memory latency + 3 cycles.
- Dirty miss: additionally EP, ER and EW.
- All val signals are held until fire. Message fields stay stable while val=1 and rdy=0.
- No new request is accepted before the response fires, i.e. one request outstanding.
- Tag and data arrays read combinationally, same cycle; writes commit at the edge.

## Test plan
- Init 0x1000 = 0xdeadbeef, then read 0x1000 → resp type 2 test 0; then resp type 0, data 0xdeadbeef, test 1, hit resp 3 cycles after accept.
- Read miss to 0x2004 with memory line {0x44,0x33,0x22,0x11} → one memreq read to addr 0x2000, no write; resp data 0x22, test 0. A repeat read gives test 1.
- Sets=8: read 0x0000, 0x0080, then 0x0000 again (hit), then 0x0100 → 0x0080 (LRU) is evicted; re-read 0x0000 hits, 0x0080 misses.
- Write 0x0008 = 0xcafe, then two conflicting reads 0x0080 and 0x0100 → memreq write to 0x0000 with word2 = 0xcafe, precedes the refill read.
- Hold cacheresp_rdy=0 for 5 cycles and memreq_rdy=0 for 3 cycles → val and messages stay stable, no duplicate memreq, cachereq_rdy=0 throughout.
- Assert reset during RW → next cycle all handshake outputs are 0; after release, a read of the same address misses (test 0).

Source files
------------

// File: rtl/lab3_mem_blocking_cache_2way_if.sv
// Message types and the bundled cache/memory handshake interface.
// slave = cache side, master = processor and memory side.
package lab3_mem_pkg;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;
endpackage

interface lab3_mem_blocking_cache_2way_if;
  import lab3_mem_pkg::*;

  logic          cachereq_val;
  logic          cachereq_rdy;
  mem_req_4B_t   cachereq_msg;
  logic          cacheresp_val;
  logic          cacheresp_rdy;
  mem_resp_4B_t  cacheresp_msg;
  logic          memreq_val;
  logic          memreq_rdy;
  mem_req_16B_t  memreq_msg;
  logic          memresp_val;
  logic          memresp_rdy;
  mem_resp_16B_t memresp_msg;

  modport slave (
    input  cachereq_val, cachereq_msg,
    output cachereq_rdy,
    output cacheresp_val, cacheresp_msg,
    input  cacheresp_rdy,
    output memreq_val, memreq_msg,
    input  memreq_rdy,
    input  memresp_val, memresp_msg,
    output memresp_rdy
  );

  modport master (
    output cachereq_val, cachereq_msg,
    input  cachereq_rdy,
    input  cacheresp_val, cacheresp_msg,
    output cacheresp_rdy,
    input  memreq_val, memreq_msg,
    output memreq_rdy,
    output memresp_val, memresp_msg,
    input  memresp_rdy
  );
endinterface

// File: rtl/lab3_mem_blocking_cache_2way.sv
// Two-way set-associative write-back write-allocate blocking cache.
// Ports: clk, reset (sync, high), bus (cache req/resp + 16B mem req/resp).
module lab3_mem_blocking_cache_2way
  import lab3_mem_pkg::*;
#(
  parameter int p_num_sets  = 8,
  parameter int p_idx_shamt = 0
) (
  input logic clk,
  input logic reset,
  lab3_mem_blocking_cache_2way_if.slave bus
);
  localparam int IW = $clog2(p_num_sets);

  typedef enum logic [3:0] {
    S_IDLE, S_TC, S_IN, S_RD, S_WD, S_EP,
    S_ER, S_EW, S_RR, S_RW, S_RU, S_WAIT
  } state_t;

  state_t state, state_n;

  logic [27:0]  tag_a  [2][p_num_sets];
  logic [127:0] data_a [2][p_num_sets];
  logic [p_num_sets-1:0] val_a [2];
  logic [p_num_sets-1:0] dty_a [2];
  logic [p_num_sets-1:0] lru;

  logic [2:0]   r_type;
  logic [7:0]   r_opq;
  logic [31:0]  r_addr;
  logic [31:0]  r_data;
  logic         r_way;
  logic         r_test;
  logic [31:0]  r_word;
  logic [31:0]  ev_addr;
  logic [127:0] ev_line;
  logic [127:0] fill;

  logic [IW-1:0] idx;
  logic [27:0]   ltag;
  logic [1:0]    wsel;
  logic          is_wr, is_in;
  logic          hit0, hit1, hit;
  logic          victim, tc_way;
  logic [127:0]  cur_line, wmask, merged;

  assign idx   = r_addr[4+p_idx_shamt +: IW];
  assign ltag  = r_addr[31:4];
  assign wsel  = r_addr[3:2];
  assign is_wr = (r_type == 3'd1);
  assign is_in = (r_type == 3'd2);

  assign hit0 = val_a[0][idx] && (tag_a[0][idx] == ltag);
  assign hit1 = val_a[1][idx] && (tag_a[1][idx] == ltag);
  assign hit  = hit0 || hit1;

  // Fill an empty way before displacing anything.
  always_comb begin
    victim = lru[idx];
    if (!val_a[0][idx])      victim = 1'b0;
    else if (!val_a[1][idx]) victim = 1'b1;
  end

  assign tc_way   = hit ? hit1 : victim;
  assign cur_line = data_a[r_way][idx];

  always_comb begin
    wmask = '0;
    wmask[{wsel, 5'b0} +: 32] = '1;
  end

  assign merged = (cur_line & ~wmask) | ({4{r_data}} & wmask);

  logic req_rdy, resp_val, mreq_val, mresp_rdy;

  always_comb begin
    state_n   = state;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    mreq_val  = 1'b0;
    mresp_rdy = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_rdy = 1'b1;
        if (bus.cachereq_val) state_n = S_TC;
      end
      S_TC: begin
        if (is_in)             state_n = S_IN;
        else if (hit)          state_n = is_wr ? S_WD : S_RD;
        else if (dty_a[victim][idx]) state_n = S_EP;
        else                   state_n = S_RR;
      end
      S_IN, S_RD, S_WD: state_n = S_WAIT;
      S_EP: state_n = S_ER;
      S_ER: begin
        mreq_val = 1'b1;
        if (bus.memreq_rdy) state_n = S_EW;
      end
      S_EW: begin
        mresp_rdy = 1'b1;
        if (bus.memresp_val) state_n = S_RR;
      end
      S_RR: begin
        mreq_val = 1'b1;
        if (bus.memreq_rdy) state_n = S_RW;
      end
      S_RW: begin
        mresp_rdy = 1'b1;
        if (bus.memresp_val) state_n = S_RU;
      end
      S_RU: state_n = is_wr ? S_WD : S_RD;
      S_WAIT: begin
        resp_val = 1'b1;
        if (bus.cacheresp_rdy) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  mem_req_16B_t mreq;
  mem_resp_4B_t cresp;

  always_comb begin
    mreq = '0;
    if (state == S_ER) begin
      mreq.type_ = 3'd1;
      mreq.addr  = ev_addr;
      mreq.data  = ev_line;
    end
    if (state == S_RR) mreq.addr = {ltag, 4'h0};
  end

  always_comb begin
    cresp = '0;
    if (state == S_WAIT) begin
      cresp.type_  = r_type;
      cresp.opaque = r_opq;
      cresp.test   = {1'b0, r_test};
      cresp.data   = r_word;
    end
  end

  // Reset forces every output quiet, whatever state was left behind.
  assign bus.cachereq_rdy  = req_rdy && !reset;
  assign bus.cacheresp_val = resp_val && !reset;
  assign bus.memreq_val    = mreq_val && !reset;
  assign bus.memresp_rdy   = mresp_rdy && !reset;
  assign bus.memreq_msg    = reset ? '0 : mreq;
  assign bus.cacheresp_msg = reset ? '0 : cresp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      val_a[0] <= '0;
      val_a[1] <= '0;
      dty_a[0] <= '0;
      dty_a[1] <= '0;
      lru      <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IN: begin
          val_a[r_way][idx] <= 1'b1;
          dty_a[r_way][idx] <= 1'b0;
          lru[idx]          <= ~r_way;
        end
        S_RD: lru[idx] <= ~r_way;
        S_WD: begin
          dty_a[r_way][idx] <= 1'b1;
          lru[idx]          <= ~r_way;
        end
        S_RU: begin
          val_a[r_way][idx] <= 1'b1;
          dty_a[r_way][idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: if (bus.cachereq_val) begin
        r_type <= bus.cachereq_msg.type_;
        r_opq  <= bus.cachereq_msg.opaque;
        r_addr <= bus.cachereq_msg.addr;
        r_data <= bus.cachereq_msg.data;
        r_word <= '0;
      end
      S_TC: begin
        r_way  <= tc_way;
        r_test <= hit && !is_in;
      end
      S_IN: begin
        tag_a[r_way][idx]  <= ltag;
        data_a[r_way][idx] <= merged;
      end
      S_RD: r_word <= cur_line[{wsel, 5'b0} +: 32];
      S_WD: data_a[r_way][idx] <= merged;
      S_EP: begin
        ev_line <= cur_line;
        ev_addr <= {tag_a[r_way][idx], 4'h0};
      end
      S_RW: if (bus.memresp_val) fill <= bus.memresp_msg.data;
      S_RU: begin
        tag_a[r_way][idx]  <= ltag;
        data_a[r_way][idx] <= fill;
      end
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{bus.cachereq_msg.len, bus.memresp_msg.type_,
                         bus.memresp_msg.opaque, bus.memresp_msg.test,
                         bus.memresp_msg.len, r_addr[1:0]};
endmodule

// File: tb/tb_lab3_mem_blocking_cache_2way.sv
// Randomised bench with a recency-list cache model and a memory responder.
// Ports: drives/observes lab3_mem_blocking_cache_2way through its interface.
module tb_lab3_mem_blocking_cache_2way;
  import lab3_mem_pkg::*;

  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  lab3_mem_blocking_cache_2way_if bus();

  lab3_mem_blocking_cache_2way #(
    .p_num_sets(8),
    .p_idx_shamt(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [255:0] act,
                              input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [27:0]  tag;
    logic [127:0] data;
    bit           dirty;
  } ent_t;
  typedef struct {
    logic [2:0]  t;
    logic [7:0]  o;
    logic [1:0]  test;
    logic [31:0] d;
  } eresp_t;
  typedef struct {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [127:0] d;
  } emreq_t;

  ent_t   cset [8][$];
  eresp_t exp_resp [$];
  emreq_t exp_mreq [$];
  emreq_t mlog [$];
  logic [127:0] mmem [logic [27:0]];
  logic [127:0] phys [logic [27:0]];

  function automatic logic [127:0] dflt(input logic [27:0] la);
    return {4{la, 4'h0}} ^ 128'h01234567_89abcdef_fedcba98_76543210;
  endfunction
  function automatic logic [127:0] mline(input logic [27:0] la);
    return mmem.exists(la) ? mmem[la] : dflt(la);
  endfunction
  function automatic logic [127:0] pline(input logic [27:0] la);
    return phys.exists(la) ? phys[la] : dflt(la);
  endfunction

  // Each set is an MRU-first list of at most two lines.
  function automatic void model_req(input logic [2:0] t, input logic [31:0] a,
                                    input logic [31:0] d, input logic [7:0] op);
    logic [27:0] la;
    int s, w, h;
    ent_t e;
    bit isw, isi;
    eresp_t r;
    emreq_t m;
    la = a[31:4];
    s = int'(a[6:4]);
    w = int'(a[3:2]);
    isw = (t == 3'd1);
    isi = (t == 3'd2);
    h = -1;
    for (int i = 0; i < cset[s].size(); i++)
      if (cset[s][i].tag == la) h = i;
    if (h >= 0) begin
      e = cset[s][h];
      cset[s].delete(h);
    end else begin
      e.data = '0;
      e.dirty = 0;
      if (cset[s].size() == 2) begin
        e = cset[s].pop_back();
        if (e.dirty && !isi) begin
          m.t = 3'd1; m.a = {e.tag, 4'h0}; m.d = e.data;
          exp_mreq.push_back(m);
          mmem[e.tag] = e.data;
        end
      end
      if (!isi) begin
        m.t = 3'd0; m.a = {la, 4'h0}; m.d = '0;
        exp_mreq.push_back(m);
        e.data = mline(la);
      end
      e.tag = la;
      e.dirty = 0;
    end
    if (isw || isi) begin
      e.data[w*32 +: 32] = d;
      e.dirty = isw;
    end
    r.t = t;
    r.o = op;
    r.test = (h >= 0 && !isi) ? 2'd1 : 2'd0;
    r.d = (isw || isi) ? 32'd0 : e.data[w*32 +: 32];
    cset[s].push_front(e);
    exp_resp.push_back(r);
  endfunction

  function automatic void flush_model();
    exp_resp.delete();
    exp_mreq.delete();
    for (int i = 0; i < 8; i++) cset[i].delete();
  endfunction

  function automatic emreq_t log_at(input int i);
    emreq_t z;
    z.t = 3'h7; z.a = '1; z.d = '1;
    return (i < mlog.size()) ? mlog[i] : z;
  endfunction

  // Compare process and shared observations
  logic p_cv, p_cr, p_mv, p_mr;
  mem_resp_4B_t p_cmsg, lresp;
  mem_req_16B_t p_mmsg, mq_msg;
  bit mq_fire, ms_fire, outstanding;
  int acc_cyc, rv_cyc, vcnt;

  initial begin
    p_cv = 0; p_cr = 0; p_mv = 0; p_mr = 0;
    mq_fire = 0; ms_fire = 0; outstanding = 0; vcnt = 0;
  end

  always @(negedge clk) begin
    mq_fire = 0;
    ms_fire = 0;
    if (reset) begin
      p_cv = 0; p_mv = 0; outstanding = 0; vcnt = 0;
    end else begin
      if (p_cv && !p_cr)
        chk("cresp_hold", {bus.cacheresp_val, bus.cacheresp_msg}, {1'b1, p_cmsg});
      if (p_mv && !p_mr)
        chk("mreq_hold", {bus.memreq_val, bus.memreq_msg}, {1'b1, p_mmsg});
      if (outstanding) chk("busy_rdy", bus.cachereq_rdy, 0);
      if (bus.cacheresp_val && !p_cv) rv_cyc = cyc;
      if (bus.cachereq_val && bus.cachereq_rdy) begin
        acc_cyc = cyc;
        outstanding = 1;
      end
      if (bus.cacheresp_val && bus.cacheresp_rdy) begin
        outstanding = 0;
        lresp = bus.cacheresp_msg;
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", bus.cacheresp_msg, '1);
        end else begin
          eresp_t r;
          r = exp_resp.pop_front();
          chk("resp", bus.cacheresp_msg, {r.t, r.o, r.test, 2'b0, r.d});
        end
      end
      if (bus.memreq_val && bus.memreq_rdy) begin
        emreq_t g;
        mq_fire = 1;
        mq_msg = bus.memreq_msg;
        g.t = bus.memreq_msg.type_;
        g.a = bus.memreq_msg.addr;
        g.d = bus.memreq_msg.data;
        mlog.push_back(g);
        if (exp_mreq.size() == 0) begin
          chk("unexpected_mreq", bus.memreq_msg, '1);
        end else begin
          emreq_t m;
          m = exp_mreq.pop_front();
          chk("mreq", bus.memreq_msg, {m.t, 8'h0, m.a, 4'h0, m.d});
        end
      end
      if (bus.memresp_val && bus.memresp_rdy) ms_fire = 1;
      if (bus.memreq_val && bus.memreq_rdy) vcnt = 0;
      else if (bus.memreq_val) vcnt++;
      p_cv = bus.cacheresp_val; p_cr = bus.cacheresp_rdy;
      p_cmsg = bus.cacheresp_msg;
      p_mv = bus.memreq_val; p_mr = bus.memreq_rdy;
      p_mmsg = bus.memreq_msg;
    end
  end

  // Memory responder
  int mrdy_mode, lat_max, lat_fix, rsp_wait;
  bit rsp_pend;
  logic [127:0] rsp_line;

  initial begin
    bus.memreq_rdy = 0;
    bus.memresp_val = 0;
    bus.memresp_msg = '0;
    rsp_pend = 0;
    rsp_wait = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.memreq_rdy = 0;
        bus.memresp_val = 0;
        bus.memresp_msg = '0;
        rsp_pend = 0;
      end else begin
        if (mq_fire) begin
          if (mq_msg.type_ == 3'd1) begin
            phys[mq_msg.addr[31:4]] = mq_msg.data;
            rsp_line = '0;
          end else begin
            rsp_line = pline(mq_msg.addr[31:4]);
          end
          rsp_pend = 1;
          rsp_wait = (lat_fix >= 0) ? lat_fix : $urandom_range(0, lat_max);
          bus.memresp_msg = '0;
          bus.memresp_msg.type_ = mq_msg.type_;
        end
        if (ms_fire) bus.memresp_val = 0;
        if (rsp_pend && !bus.memresp_val) begin
          if (rsp_wait == 0) begin
            bus.memresp_val = 1;
            bus.memresp_msg.data = rsp_line;
            rsp_pend = 0;
          end else begin
            rsp_wait--;
          end
        end
        case (mrdy_mode)
          0: bus.memreq_rdy = 1;
          1: bus.memreq_rdy = ($urandom_range(0, 3) != 0);
          default: bus.memreq_rdy = (vcnt >= 3);
        endcase
      end
    end
  end

  // Processor-side driver
  int cr_mode;

  task automatic send(input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] d);
    int n, hc;
    bit ok;
    logic [7:0] op;
    op = 8'($urandom);
    model_req(t, a, d, op);
    bus.cachereq_val = 1;
    bus.cachereq_msg = '{type_: t, opaque: op, addr: a, len: 2'd0, data: d};
    n = 0;
    ok = 1;
    forever begin
      @(negedge clk);
      if (bus.cachereq_rdy) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 0, 1);
        ok = 0;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cachereq_val = 0;
    bus.cachereq_msg = '0;
    if (ok) begin
      n = 0;
      hc = 0;
      forever begin
        case (cr_mode)
          0: bus.cacheresp_rdy = 1;
          1: bus.cacheresp_rdy = 1'($urandom_range(0, 1));
          default: bus.cacheresp_rdy = (hc >= 5);
        endcase
        @(negedge clk);
        if (bus.cacheresp_val && bus.cacheresp_rdy) break;
        if (bus.cacheresp_val) hc++;
        n++;
        if (n > 400) begin
          chk("resp_timeout", 0, 1);
          break;
        end
        @(posedge clk);
        #1;
      end
      @(posedge clk);
      #1;
      bus.cacheresp_rdy = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  function automatic logic [255:0] quiet();
    return {bus.cachereq_rdy, bus.cacheresp_val, bus.memreq_val,
            bus.memresp_rdy, bus.cacheresp_msg, bus.memreq_msg};
  endfunction

  initial begin
    int n;
    emreq_t e0, e1;
    bus.cachereq_val = 0;
    bus.cachereq_msg = '0;
    bus.cacheresp_rdy = 0;
    cr_mode = 0;
    mrdy_mode = 0;
    lat_max = 2;
    lat_fix = -1;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_quiet", quiet(), 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rdy_after_reset", bus.cachereq_rdy, 1);
    @(posedge clk);
    #1;

    // init then read hit
    send(3'd2, 32'h1000, 32'hdeadbeef);
    chk("init_resp", {lresp.type_, lresp.test, lresp.data}, {3'd2, 2'd0, 32'd0});
    send(3'd0, 32'h1000, 0);
    chk("init_read", {lresp.type_, lresp.test, lresp.data},
        {3'd0, 2'd1, 32'hdeadbeef});
    chk("hit_latency", rv_cyc - acc_cyc, 3);

    // clean read miss with a known line
    mmem[28'h200] = 128'h00000044_00000033_00000022_00000011;
    phys[28'h200] = 128'h00000044_00000033_00000022_00000011;
    mlog.delete();
    send(3'd0, 32'h2004, 0);
    chk("miss_data", {lresp.test, lresp.data}, {2'd0, 32'h22});
    e0 = log_at(0);
    chk("miss_mreq", {mlog.size(), e0.t, e0.a}, {32'd1, 3'd0, 32'h2000});
    send(3'd0, 32'h2004, 0);
    chk("repeat_hit", {lresp.test, lresp.data}, {2'd1, 32'h22});

    // LRU replacement
    do_reset();
    send(3'd0, 32'h0000, 0);
    send(3'd0, 32'h0080, 0);
    send(3'd0, 32'h0000, 0);
    chk("lru_hit0", lresp.test, 1);
    send(3'd0, 32'h0100, 0);
    chk("lru_miss100", lresp.test, 0);
    send(3'd0, 32'h0000, 0);
    chk("lru_keep0", lresp.test, 1);
    send(3'd0, 32'h0080, 0);
    chk("lru_evict80", lresp.test, 0);

    // dirty eviction ordering
    do_reset();
    send(3'd1, 32'h0008, 32'h0000cafe);
    send(3'd0, 32'h0080, 0);
    mlog.delete();
    send(3'd0, 32'h0100, 0);
    e0 = log_at(0);
    e1 = log_at(1);
    chk("wb_count", mlog.size(), 2);
    chk("wb_first", {e0.t, e0.a, e0.d[95:64]}, {3'd1, 32'h0, 32'h0000cafe});
    chk("refill_second", {e1.t, e1.a}, {3'd0, 32'h0100});

    // back-pressure on both sides
    cr_mode = 2;
    mrdy_mode = 2;
    mlog.delete();
    send(3'd0, 32'h0200, 0);
    chk("stall_one_mreq", mlog.size(), 1);
    send(3'd1, 32'h0104, 32'h12345678);
    send(3'd0, 32'h0300, 0);
    cr_mode = 0;
    mrdy_mode = 0;

    // reset while waiting for the refill
    do_reset();
    lat_fix = 12;
    model_req(3'd0, 32'h3000, 0, 8'h11);
    bus.cachereq_val = 1;
    bus.cachereq_msg = '{type_: 3'd0, opaque: 8'h11, addr: 32'h3000,
                         len: 2'd0, data: 32'd0};
    mlog.delete();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cachereq_rdy && n < 50);
    @(posedge clk);
    #1;
    bus.cachereq_val = 0;
    bus.cachereq_msg = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mlog.size() == 0 && n < 50);
    chk("abort_reached_rw", mlog.size(), 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1;
    flush_model();
    @(negedge clk);
    chk("abort_quiet", quiet(), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    lat_fix = -1;
    send(3'd0, 32'h3000, 0);
    chk("abort_remiss", lresp.test, 0);

    // randomised traffic
    do_reset();
    cr_mode = 1;
    mrdy_mode = 1;
    lat_max = 3;
    repeat (400) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 7)) << 7) | (32'($urandom_range(0, 1)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      send(3'($urandom_range(0, 1)), a, $urandom);
    end
    repeat (5) @(posedge clk);
    chk("drained", {exp_resp.size(), exp_mreq.size()}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    errs++;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end
endmodule
